pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 13 +
 rtl/pc_gen_ras_stack.sv | 58 +++++
 rtl/pc_gen.sv | 87 ++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared control encodings for the fetch-side next-PC logic.
package pc_gen_pkg;

  localparam int unsigned NPC_OP_W = 4;

  localparam logic [NPC_OP_W-1:0] NPC_PLUS4  = 4'd0;
  localparam logic [NPC_OP_W-1:0] NPC_BRANCH = 4'd1;
  localparam logic [NPC_OP_W-1:0] NPC_JUMP   = 4'd2;
  localparam logic [NPC_OP_W-1:0] NPC_JR     = 4'd3;
  localparam logic [NPC_OP_W-1:0] NPC_JAL    = 4'd4;
  localparam logic [NPC_OP_W-1:0] NPC_RET    = 4'd5;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: pushes past capacity overwrite the oldest entry.
module ras_stack #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PC_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(RAS_DEPTH));
  assign top   = empty ? '0 : mem[ptr_q];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push) begin
      // When full the pointer advances onto the oldest slot, so count saturates.
      ptr_d = ptr_q + PW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[ptr_q + PW'(1)] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator with a return-address stack for JAL/RET prediction checks.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                flush,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                br_taken,
  input  logic [25:0]         imm,
  input  logic [PC_W-1:0]     rd,
  output logic [PC_W-1:0]     pc,
  output logic [PC_W-1:0]     npc,
  output logic [PC_W-1:0]     ras_top,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ret_mismatch,
  output logic                ras_underflow
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pcplus4;
  logic [PC_W-1:0] br_offset;
  logic            jal_go, ret_go;
  logic            mismatch_q, underflow_q;

  assign pcplus4   = pc_q + PC_W'(4);
  assign br_offset = {{(PC_W-18){imm[15]}}, imm[15:0], 2'b00};

  always_comb begin
    npc = pcplus4;
    case (npc_op)
      NPC_PLUS4:          npc = pcplus4;
      NPC_BRANCH:         npc = br_taken ? (pcplus4 + br_offset) : pcplus4;
      NPC_JUMP, NPC_JAL:  npc = {pcplus4[PC_W-1:28], imm, 2'b00};
      NPC_JR, NPC_RET:    npc = rd;
      default:            npc = pcplus4;
    endcase
  end

  assign jal_go = (npc_op == NPC_JAL) && !stall;
  assign ret_go = (npc_op == NPC_RET) && !stall;

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .push      (jal_go),
    .pop       (ret_go),
    .flush     (flush),
    .push_data (pcplus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      pc_q <= npc;
    end
  end

  // Pulses are recomputed every edge, so a stalled RET leaves them low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mismatch_q  <= ret_go && !ras_empty && (rd != ras_top);
      underflow_q <= ret_go && ras_empty;
    end
  end

  assign pc            = pc_q;
  assign ret_mismatch  = mismatch_q;
  assign ras_underflow = underflow_q;

endmodule
